// File: rtl/afe_config_pkg.sv
// rtl/afe_config_pkg.sv - opcodes, state encodings and word size shared by the AFE config sequencer
package afe_config_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h1;
  localparam logic [3:0] OP_WAIT  = 4'h2;
  localparam logic [3:0] OP_JUMP  = 4'h3;
  localparam logic [3:0] OP_PIN   = 4'h4;
  localparam logic [3:0] OP_END   = 4'hF;

  localparam int SHIFT_BITS = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_LOW,
    PH_HIGH,
    PH_GAP
  } spi_phase_t;

endpackage

// File: rtl/afe_spi_shifter.sv
// rtl/afe_spi_shifter.sv - mode-0 SPI serialiser: load pulse in, 20 bits MSB first, CS gap, done pulse out
module afe_spi_shifter
  import afe_config_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [SHIFT_BITS-1:0] data,
  output logic                  sclk,
  output logic                  sdata,
  output logic                  cs_n,
  output logic                  done
);

  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);

  spi_phase_t            phase;
  logic [7:0]            div_cnt;
  logic [4:0]            bit_idx;
  logic [SHIFT_BITS-1:0] word;
  logic                  div_end;

  assign div_end = (div_cnt == DIV_LAST);
  // Combinational so the sequencer can fetch on the very next cycle after the gap.
  assign done    = (phase == PH_GAP) && div_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase   <= PH_IDLE;
      div_cnt <= 8'd0;
      bit_idx <= 5'd0;
      word    <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (load) begin
            phase   <= PH_LOW;
            div_cnt <= 8'd0;
            word    <= data;
            bit_idx <= 5'(SHIFT_BITS - 1);
            sdata   <= data[SHIFT_BITS-1];
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
          end
        end
        PH_LOW: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b1;
            phase   <= PH_HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        PH_HIGH: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b0;
            if (bit_idx == 5'd0) begin
              phase <= PH_GAP;
              cs_n  <= 1'b1;
              sdata <= 1'b0;
            end else begin
              // Data moves together with the falling edge, never while sclk is high.
              bit_idx <= bit_idx - 5'd1;
              sdata   <= word[bit_idx-5'd1];
              phase   <= PH_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        PH_GAP: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            phase   <= PH_IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/afe_config_sequencer.sv
// rtl/afe_config_sequencer.sv - walks the AFE command ROM, decodes opcodes and drives the AFE SPI and reset pins
module afe_config_sequencer
  import afe_config_pkg::*;
#(
  parameter int         SCLK_DIV      = 4,
  parameter logic [7:0] START_ADDRESS = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [7:0]            rom_address,
  input  logic [3:0]            controller_command,
  input  logic [SHIFT_BITS-1:0] afe_shift_data,
  output logic                  afe_sclk,
  output logic                  afe_sdata,
  output logic                  afe_cs_n,
  output logic                  afe_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  seq_state_t            state, state_next;
  logic [7:0]            address_next;
  logic                  busy_next, done_next, error_next, reset_pin_next;
  logic [SHIFT_BITS-1:0] wait_cnt, wait_next;
  logic                  spi_load, spi_done;

  afe_spi_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (spi_load),
    .data  (afe_shift_data),
    .sclk  (afe_sclk),
    .sdata (afe_sdata),
    .cs_n  (afe_cs_n),
    .done  (spi_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rom_address <= START_ADDRESS;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      afe_reset_n <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_next;
      rom_address <= address_next;
      busy        <= busy_next;
      done        <= done_next;
      error       <= error_next;
      afe_reset_n <= reset_pin_next;
      wait_cnt    <= wait_next;
    end
  end

  always_comb begin
    state_next     = state;
    address_next   = rom_address;
    busy_next      = busy;
    done_next      = done;
    error_next     = error;
    reset_pin_next = afe_reset_n;
    wait_next      = wait_cnt;
    spi_load       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          address_next = START_ADDRESS;
          busy_next    = 1'b1;
          done_next    = 1'b0;
          error_next   = 1'b0;
          state_next   = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: begin
        case (controller_command)
          OP_NOP: begin
            address_next = rom_address + 8'd1;
            state_next   = ST_FETCH;
          end
          OP_PIN: begin
            reset_pin_next = afe_shift_data[0];
            address_next   = rom_address + 8'd1;
            state_next     = ST_FETCH;
          end
          OP_JUMP: begin
            address_next = afe_shift_data[7:0];
            state_next   = ST_FETCH;
          end
          OP_SHIFT: begin
            spi_load   = 1'b1;
            state_next = ST_SHIFT;
          end
          OP_WAIT: begin
            if (afe_shift_data == '0) begin
              address_next = rom_address + 8'd1;
              state_next   = ST_FETCH;
            end else begin
              wait_next  = afe_shift_data;
              state_next = ST_WAIT;
            end
          end
          OP_END: begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = ST_DONE;
          end
          default: begin
            busy_next  = 1'b0;
            error_next = 1'b1;
            state_next = ST_ERROR;
          end
        endcase
      end
      ST_WAIT: begin
        if (wait_cnt == 20'd1) begin
          address_next = rom_address + 8'd1;
          state_next   = ST_FETCH;
        end else begin
          wait_next = wait_cnt - 20'd1;
        end
      end
      ST_SHIFT: begin
        if (spi_done) begin
          address_next = rom_address + 8'd1;
          state_next   = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/afe_config_sequencer.md
Name: afe_config_sequencer

Overview:
- Consumer side of the AFE command ROM: walks ROM addresses, decodes each 4-bit controller command and executes it.
- Executes by serialising 20-bit configuration words to the AFE over a 3-wire SPI (mode 0), inserting delays, jumping, or driving the AFE reset pin.
- Sits between the command ROM (registered read, 1-cycle latency) and the AFE pins; a single start pulse runs the whole power-up configuration program.

Parameters:
- SCLK_DIV, 4: clk cycles per SPI half-period; valid range 1..255.
- START_ADDRESS, 8'h00: first ROM address fetched after start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; launches the program from START_ADDRESS.
- rom_address  out  8  registered ROM address.
- controller_command  in  4  ROM opcode, valid 1 cycle after rom_address.
- afe_shift_data  in  20  ROM operand, same timing as controller_command.
- afe_sclk  out  1  SPI clock; idles low.
- afe_sdata  out  1  SPI data, MSB first.
- afe_cs_n  out  1  SPI chip select, active low.
- afe_reset_n  out  1  AFE hardware reset.
- busy  out  1  high while the program is executing.
- done  out  1  sticky; program reached END.
- error  out  1  sticky; an illegal opcode was decoded.

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high. All state and outputs are registered.
- Reset values: rom_address=START_ADDRESS, afe_sclk=0, afe_sdata=0, afe_cs_n=1, afe_reset_n=0, busy=0, done=0, error=0, state=IDLE.
- Reset asserted mid-transfer: all outputs return to reset values immediately and the partial SPI word is abandoned.

Opcodes (controller_command):
- 0 NOP.
- 1 SHIFT: send operand[19:0].
- 2 WAIT: stall for operand cycles.
- 3 JUMP: rom_address = operand[7:0].
- 4 PIN: afe_reset_n = operand[0].
- F END.
- Any other value is illegal → ERROR.

States:
- IDLE: start → rom_address=START_ADDRESS, busy=1, done=0, error=0; go to FETCH.
- FETCH: one cycle while the ROM registers the data; go to DECODE.
- DECODE: sample controller_command and afe_shift_data.
  - NOP, PIN: rom_address+1; go to FETCH.
  - JUMP: load operand[7:0]; go to FETCH.
  - SHIFT: go to SPI_LOW.
  - WAIT: go to WAIT, or to FETCH if operand==0.
  - END: go to DONE.
  - illegal: go to ERROR.
- Address increment wraps 8'hFF→8'h00.
- Fetch cost: each NOP/PIN/JUMP instruction costs exactly 2 cycles (FETCH+DECODE).
- WAIT: a 20-bit down-counter is loaded with the operand. Exactly operand cycles are spent in WAIT, then rom_address+1 and go to FETCH.
- SPI_LOW / SPI_HIGH (20 bits, index 19→0):
  - Entering SPI_LOW: afe_cs_n=0, afe_sclk=0, afe_sdata=current bit; hold SCLK_DIV cycles.
  - SPI_HIGH: afe_sclk=1 for SCLK_DIV cycles, then next bit in SPI_LOW.
  - After bit 0's high phase go to CS_GAP.
  - afe_sdata changes only while afe_sclk is low. The AFE samples on the rising edge.
- CS_GAP: afe_cs_n=1, afe_sclk=0 for SCLK_DIV cycles, then rom_address+1 and go to FETCH.
  - SHIFT timing: afe_cs_n low for 40*SCLK_DIV cycles; whole instruction = 2 + 41*SCLK_DIV cycles.
- DONE: busy=0, done=1; afe_reset_n keeps its last value.
- ERROR: busy=0, error=1, afe_cs_n=1; rom_address holds the faulting address+0.
- start from DONE or ERROR clears the sticky flags and relaunches. start while busy is ignored.
- A JUMP to its own address loops forever; this is legal and busy stays 1.

Decomposition:
- Package afe_config_pkg holds:
  - opcode localparams OP_NOP=4'h0, OP_SHIFT=4'h1, OP_WAIT=4'h2, OP_JUMP=4'h3, OP_PIN=4'h4, OP_END=4'hF;
  - the state encoding;
  - the SHIFT_BITS=20 constant.
- Sub-module afe_spi_shifter:
  - handles load/bit-count/divider and generates sclk, sdata and cs_n;
  - handshake is a load pulse in, a done pulse out;
  - the sequencer FSM remains in the top module.

Test Plan:
- ROM {0:1_A5A5A, 1:F_00000}, SCLK_DIV=4, pulse start:
  - afe_cs_n low for 160 cycles;
  - 20 rising edges sample 1010_0101_1010_0101_1010;
  - CS_GAP of 4 cycles; done=1, busy=0.
- ROM {0:4_00001, 1:2_00064, 2:4_00000, 3:F}: afe_reset_n rises at DECODE of address 0, then falls exactly 100+2 cycles after WAIT entry; done=1.
- ROM {0:3_000FE, FE:0, FF:0, 00 revisit guard via 0:...}: JUMP to FE, NOP at FE, NOP at FF, address wraps to 00. Verify rom_address sequence 00,FE,FF,00.
- ROM {0:0, 1:7_12345}: error=1, busy=0, rom_address=01, afe_cs_n=1. A subsequent start with a fixed ROM clears error.
- Assert reset on the 10th bit of a SHIFT: afe_cs_n=1, afe_sclk=0, afe_reset_n=0, rom_address=00 in the same cycle. Reissued start resends the full word.
- start pulsed during WAIT: ignored, with no address change. WAIT operand 0 passes straight to FETCH (2-cycle instruction).
